// File: rtl/rv32i_types_pkg.sv
// Shared types for the 5-stage pipeline.
//   mem_type_t  : load/store width and signedness (B, H, W, BU, HU)
//   W_SEL_*     : integer writeback source select encodings
//   F_WSEL_*    : FP writeback source select encodings
//   mem_state_t : MEM-stage bus FSM states
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_type_t;

  localparam logic [2:0] W_SEL_LOAD = 3'd0;
  localparam logic [2:0] W_SEL_ALU  = 3'd3;
  localparam logic [2:0] W_SEL_CSR  = 3'd4;

  localparam logic [1:0] F_WSEL_FPU  = 2'd0;
  localparam logic [1:0] F_WSEL_LOAD = 2'd1;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/pipe5_mem_lane_steer.sv
// Combinational byte-lane steering for the MEM stage.
//   mem_type   : access width/signedness (mem_type_t encoding)
//   addr_lo    : low two address bits selecting the lane
//   store_data : unaligned store source (low bits hold the value)
//   rdata      : full bus word returned by a load
//   wdata      : store data replicated across every lane of its width
//   byte_en    : byte enables for loads and stores
//   load_ext   : selected lane, sign- or zero-extended
//   aligned    : access is naturally aligned for its width
module pipe5_mem_lane_steer
  import rv32i_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      mem_type,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] load_ext,
  output logic            aligned
);

  function automatic logic [31:0] sext_byte(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic [31:0] sext_half(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    wdata    = store_data;
    byte_en  = 4'b1111;
    load_ext = rdata;
    aligned  = 1'b1;
    case (mem_type)
      MEM_B, MEM_BU: begin
        wdata    = {4{store_data[7:0]}};
        byte_en  = 4'b0001 << addr_lo;
        load_ext = (mem_type == MEM_B) ? sext_byte(byte_sel) : {24'b0, byte_sel};
      end
      MEM_H, MEM_HU: begin
        wdata    = {2{store_data[15:0]}};
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_ext = (mem_type == MEM_H) ? sext_half(half_sel) : {16'b0, half_sel};
        aligned  = ~addr_lo[0];
      end
      // Word and any unused encoding behave as a full-word access.
      default: aligned = (addr_lo == 2'b00);
    endcase
  end

endmodule

// File: rtl/pipe5_memory_stage.sv
// MEM stage of the 5-stage pipeline.
//   CLK, RST          : clock, synchronous active-high reset
//   ex_*              : EX/MEM register contents (control, data, memory request)
//   flush             : kill the instruction currently in MEM
//   dmem_*            : busy-handshake data bus (strobes, address, data, enables)
//   mem_stall         : hold IF..EX and EX/MEM while a bus access is pending
//   misaligned        : one-cycle pulse for a misaligned load/store
//   wb_*              : MEM/WB pipeline register feeding writeback
// A bus access that has been issued is always run to completion; a flush
// arriving while it is outstanding only suppresses the register write.
module pipe5_memory_stage
  import rv32i_types_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ex_valid,
  input  logic                 ex_wen,
  input  logic                 ex_f_wen,
  input  logic [RF_ADDR_W-1:0] ex_reg_rd,
  input  logic [2:0]           ex_w_sel,
  input  logic [1:0]           ex_f_wsel,
  input  logic [XLEN-1:0]      ex_alu_out,
  input  logic [XLEN-1:0]      ex_csr_rdata,
  input  logic [XLEN-1:0]      ex_reg_file_wdata,
  input  logic [XLEN-1:0]      ex_fpu_out,
  input  logic [XLEN-1:0]      ex_f_wdata,
  input  logic                 ex_dren,
  input  logic                 ex_dwen,
  input  logic [2:0]           ex_mem_type,
  input  logic [XLEN-1:0]      ex_store_data,
  input  logic                 flush,
  output logic                 dmem_ren,
  output logic                 dmem_wen,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [3:0]           dmem_byte_en,
  input  logic                 dmem_busy,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 mem_stall,
  output logic                 misaligned,
  output logic                 wb_wen,
  output logic                 wb_f_wen,
  output logic [RF_ADDR_W-1:0] wb_reg_rd,
  output logic [2:0]           wb_w_sel,
  output logic [1:0]           wb_f_wsel,
  output logic [XLEN-1:0]      wb_alu_port_out,
  output logic [XLEN-1:0]      wb_dload_ext,
  output logic [XLEN-1:0]      wb_csr_rdata,
  output logic [XLEN-1:0]      wb_reg_file_wdata,
  output logic [XLEN-1:0]      wb_fpu_out,
  output logic [XLEN-1:0]      wb_f_wdata
);

  mem_state_t      state;
  logic            kill;
  logic            req_ren, req_wen;
  logic [XLEN-1:0] req_addr, req_sdata;
  logic [2:0]      req_type;

  logic            in_wait;
  logic [XLEN-1:0] cur_addr, cur_sdata;
  logic [2:0]      cur_type;
  logic [XLEN-1:0] steer_wdata, load_ext;
  logic [3:0]      steer_be;
  logic            aligned;
  logic            mem_req, access, misalign_int, stall_int, bubble;

  assign in_wait = (state == MEM_WAIT);

  // While waiting, the latched request drives the bus so it stays stable
  // even if the EX/MEM contents are flushed underneath it.
  assign cur_addr  = in_wait ? req_addr  : ex_alu_out;
  assign cur_sdata = in_wait ? req_sdata : ex_store_data;
  assign cur_type  = in_wait ? req_type  : ex_mem_type;

  pipe5_mem_lane_steer #(.XLEN(XLEN)) u_steer (
    .mem_type   (cur_type),
    .addr_lo    (cur_addr[1:0]),
    .store_data (cur_sdata),
    .rdata      (dmem_rdata),
    .wdata      (steer_wdata),
    .byte_en    (steer_be),
    .load_ext   (load_ext),
    .aligned    (aligned)
  );

  assign mem_req      = ex_valid & (ex_dren | ex_dwen);
  assign access       = ~in_wait & mem_req & aligned;
  assign misalign_int = ~in_wait & mem_req & ~aligned;
  assign stall_int    = (access | in_wait) & dmem_busy;
  assign bubble       = stall_int | flush | kill | misalign_int;

  assign dmem_ren     = ~RST & ((access & ex_dren) | (in_wait & req_ren));
  assign dmem_wen     = ~RST & ((access & ex_dwen) | (in_wait & req_wen));
  assign dmem_addr    = {cur_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata   = steer_wdata;
  assign dmem_byte_en = steer_be;
  assign mem_stall    = ~RST & stall_int;
  assign misaligned   = ~RST & misalign_int;

  // Bus FSM control and MEM/WB register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= MEM_IDLE;
      kill              <= 1'b0;
      req_ren           <= 1'b0;
      req_wen           <= 1'b0;
      wb_wen            <= 1'b0;
      wb_f_wen          <= 1'b0;
      wb_reg_rd         <= '0;
      wb_w_sel          <= '0;
      wb_f_wsel         <= '0;
      wb_alu_port_out   <= '0;
      wb_dload_ext      <= '0;
      wb_csr_rdata      <= '0;
      wb_reg_file_wdata <= '0;
      wb_fpu_out        <= '0;
      wb_f_wdata        <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (access & dmem_busy) begin
            state   <= MEM_WAIT;
            kill    <= flush;
            req_ren <= ex_dren;
            req_wen <= ex_dwen;
          end
        end
        MEM_WAIT: begin
          if (!dmem_busy) begin
            state <= MEM_IDLE;
            kill  <= 1'b0;
          end else if (flush) begin
            kill <= 1'b1;
          end
        end
        default: state <= MEM_IDLE;
      endcase

      // Data fields are don't-care under a bubble; only the enables matter.
      wb_wen            <= ~bubble & ex_valid & ex_wen;
      wb_f_wen          <= ~bubble & ex_valid & ex_f_wen;
      wb_reg_rd         <= ex_reg_rd;
      wb_w_sel          <= ex_w_sel;
      wb_f_wsel         <= ex_f_wsel;
      wb_alu_port_out   <= ex_alu_out;
      wb_dload_ext      <= load_ext;
      wb_csr_rdata      <= ex_csr_rdata;
      wb_reg_file_wdata <= ex_reg_file_wdata;
      wb_fpu_out        <= ex_fpu_out;
      wb_f_wdata        <= ex_f_wdata;
    end
  end

  // Latched request payload (no reset needed: only read while waiting)
  always_ff @(posedge CLK) begin
    if (!in_wait && access && dmem_busy) begin
      req_addr  <= ex_alu_out;
      req_sdata <= ex_store_data;
      req_type  <= ex_mem_type;
    end
  end

endmodule

// File: tb/tb_pipe5_memory_stage.sv
module tb_pipe5_memory_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ex_valid, ex_wen, ex_f_wen;
  logic [4:0]  ex_reg_rd;
  logic [2:0]  ex_w_sel;
  logic [1:0]  ex_f_wsel;
  logic [31:0] ex_alu_out, ex_csr_rdata, ex_reg_file_wdata, ex_fpu_out, ex_f_wdata;
  logic        ex_dren, ex_dwen;
  logic [2:0]  ex_mem_type;
  logic [31:0] ex_store_data;
  logic        flush;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_busy;
  logic [31:0] dmem_rdata;
  logic        mem_stall, misaligned;
  logic        wb_wen, wb_f_wen;
  logic [4:0]  wb_reg_rd;
  logic [2:0]  wb_w_sel;
  logic [1:0]  wb_f_wsel;
  logic [31:0] wb_alu_port_out, wb_dload_ext, wb_csr_rdata, wb_reg_file_wdata, wb_fpu_out, wb_f_wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  pipe5_memory_stage dut (
    .CLK(CLK), .RST(RST),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_f_wen(ex_f_wen),
    .ex_reg_rd(ex_reg_rd), .ex_w_sel(ex_w_sel), .ex_f_wsel(ex_f_wsel),
    .ex_alu_out(ex_alu_out), .ex_csr_rdata(ex_csr_rdata),
    .ex_reg_file_wdata(ex_reg_file_wdata), .ex_fpu_out(ex_fpu_out),
    .ex_f_wdata(ex_f_wdata), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
    .ex_mem_type(ex_mem_type), .ex_store_data(ex_store_data), .flush(flush),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_busy(dmem_busy), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .misaligned(misaligned),
    .wb_wen(wb_wen), .wb_f_wen(wb_f_wen), .wb_reg_rd(wb_reg_rd),
    .wb_w_sel(wb_w_sel), .wb_f_wsel(wb_f_wsel),
    .wb_alu_port_out(wb_alu_port_out), .wb_dload_ext(wb_dload_ext),
    .wb_csr_rdata(wb_csr_rdata), .wb_reg_file_wdata(wb_reg_file_wdata),
    .wb_fpu_out(wb_fpu_out), .wb_f_wdata(wb_f_wdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] m);
    if (m == 3'd0 || m == 3'd4) return 1;
    if (m == 3'd1 || m == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_aligned(input logic [2:0] m, input logic [31:0] a);
    return (a % m_size(m)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] m, input logic [31:0] a);
    int s;
    s = m_size(m);
    if (s == 1) return 4'(1 << (a % 4));
    if (s == 2) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] d);
    int s;
    s = m_size(m);
    if (s == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] m, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int s;
    s = m_size(m);
    if (s == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (m == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = (rd >> (8 * (a % 4))) & 32'hFFFF;
      if (m == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic set_ex(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] mt,
                        input logic [31:0] addr, input logic [31:0] sd, input logic wen,
                        input logic fwen, input logic [2:0] wsel, input logic [1:0] fwsel);
    ex_valid = v; ex_dren = rd_en; ex_dwen = wr_en; ex_mem_type = mt;
    ex_alu_out = addr; ex_store_data = sd; ex_wen = wen; ex_f_wen = fwen;
    ex_w_sel = wsel; ex_f_wsel = fwsel; ex_reg_rd = 5'($urandom);
    ex_csr_rdata = $urandom; ex_reg_file_wdata = $urandom;
    ex_fpu_out = $urandom; ex_f_wdata = $urandom;
  endtask

  // Runs the instruction currently on ex_* to completion; called at posedge+1.
  task automatic run_txn(input int busy_n, input int flush_cyc, input logic [31:0] rd);
    logic acc, mis, killed, done, exp_wen, exp_fwen, exp_stall;
    logic [4:0] rd_sav;
    logic [2:0] wsel_sav;
    logic [1:0] fwsel_sav;
    logic [31:0] alu_sav, csr_sav, rfw_sav, fpu_sav, fw_sav, ext_exp;
    int c;
    acc = ex_valid & (ex_dren | ex_dwen) & m_aligned(ex_mem_type, ex_alu_out);
    mis = ex_valid & (ex_dren | ex_dwen) & ~m_aligned(ex_mem_type, ex_alu_out);
    ext_exp = m_ext(ex_mem_type, ex_alu_out, rd);
    rd_sav = ex_reg_rd; wsel_sav = ex_w_sel; fwsel_sav = ex_f_wsel; alu_sav = ex_alu_out;
    csr_sav = ex_csr_rdata; rfw_sav = ex_reg_file_wdata; fpu_sav = ex_fpu_out; fw_sav = ex_f_wdata;
    killed = 1'b0; done = 1'b0; c = 0;
    while (!done) begin
      dmem_busy = acc && (c < busy_n);
      flush = (c == flush_cyc);
      dmem_rdata = dmem_busy ? $urandom : rd;
      exp_stall = dmem_busy;
      #3;
      vectors += 4;
      if (dmem_ren !== (acc & ex_dren)) begin miscompares++; $display("FAIL ren c=%0d got=%b exp=%b", c, dmem_ren, acc & ex_dren); end
      if (dmem_wen !== (acc & ex_dwen)) begin miscompares++; $display("FAIL wen c=%0d got=%b exp=%b", c, dmem_wen, acc & ex_dwen); end
      if (mem_stall !== exp_stall) begin miscompares++; $display("FAIL stall c=%0d got=%b exp=%b", c, mem_stall, exp_stall); end
      if (misaligned !== (mis && c == 0)) begin miscompares++; $display("FAIL misaligned c=%0d got=%b exp=%b", c, misaligned, mis && c == 0); end
      if (acc) begin
        vectors += 2;
        if (dmem_addr !== (alu_sav & ~32'h3)) begin miscompares++; $display("FAIL addr got=%h exp=%h", dmem_addr, alu_sav & ~32'h3); end
        if (dmem_byte_en !== m_be(ex_mem_type, alu_sav)) begin miscompares++; $display("FAIL byte_en got=%b exp=%b", dmem_byte_en, m_be(ex_mem_type, alu_sav)); end
        if (ex_dwen) begin
          vectors++;
          if (dmem_wdata !== m_wdata(ex_mem_type, ex_store_data)) begin miscompares++; $display("FAIL wdata got=%h exp=%h", dmem_wdata, m_wdata(ex_mem_type, ex_store_data)); end
        end
      end
      if (flush) killed = 1'b1;
      done = !dmem_busy;
      @(posedge CLK); #1;
      if (!done) begin
        vectors++;
        if (wb_wen !== 1'b0 || wb_f_wen !== 1'b0) begin miscompares++; $display("FAIL stall_bubble got=%b%b exp=00", wb_wen, wb_f_wen); end
      end
      c++;
      if (c > 50) begin miscompares++; $display("FAIL timeout waiting for completion"); done = 1'b1; end
    end
    exp_wen  = ex_valid & ex_wen & ~killed & ~mis;
    exp_fwen = ex_valid & ex_f_wen & ~killed & ~mis;
    ex_valid = 1'b0; flush = 1'b0; dmem_busy = 1'b0;
    vectors += 2;
    if (wb_wen !== exp_wen) begin miscompares++; $display("FAIL wb_wen got=%b exp=%b", wb_wen, exp_wen); end
    if (wb_f_wen !== exp_fwen) begin miscompares++; $display("FAIL wb_f_wen got=%b exp=%b", wb_f_wen, exp_fwen); end
    if (exp_wen | exp_fwen) begin
      vectors += 4;
      if (wb_reg_rd !== rd_sav || wb_w_sel !== wsel_sav || wb_f_wsel !== fwsel_sav) begin
        miscompares++; $display("FAIL wb_ctrl got=%h/%h/%h exp=%h/%h/%h", wb_reg_rd, wb_w_sel, wb_f_wsel, rd_sav, wsel_sav, fwsel_sav);
      end
      if (wb_alu_port_out !== alu_sav) begin miscompares++; $display("FAIL wb_alu got=%h exp=%h", wb_alu_port_out, alu_sav); end
      if (wb_csr_rdata !== csr_sav || wb_reg_file_wdata !== rfw_sav) begin miscompares++; $display("FAIL wb_csr_rfw got=%h/%h exp=%h/%h", wb_csr_rdata, wb_reg_file_wdata, csr_sav, rfw_sav); end
      if (wb_fpu_out !== fpu_sav || wb_f_wdata !== fw_sav) begin miscompares++; $display("FAIL wb_fp got=%h/%h exp=%h/%h", wb_fpu_out, wb_f_wdata, fpu_sav, fw_sav); end
      if (acc && ex_dren) begin
        vectors++;
        if (wb_dload_ext !== ext_exp) begin miscompares++; $display("FAIL wb_dload_ext got=%h exp=%h", wb_dload_ext, ext_exp); end
      end
    end
  endtask

  task automatic check_wb_zero(input string tag);
    vectors++;
    if ({wb_wen, wb_f_wen, wb_reg_rd, wb_w_sel, wb_f_wsel, wb_alu_port_out, wb_dload_ext,
         wb_csr_rdata, wb_reg_file_wdata, wb_fpu_out, wb_f_wdata} !== '0) begin
      miscompares++; $display("FAIL %s wb not zero: wen=%b fwen=%b rd=%h alu=%h ext=%h", tag, wb_wen, wb_f_wen, wb_reg_rd, wb_alu_port_out, wb_dload_ext);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; dmem_busy = 1'b1; dmem_rdata = '0;
    set_ex(1, 1, 0, 3'd2, 32'h100, 0, 1, 0, 0, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #2;
    vectors += 3;
    if (dmem_ren !== 1'b0 || dmem_wen !== 1'b0) begin miscompares++; $display("FAIL reset_strobes got=%b%b exp=00", dmem_ren, dmem_wen); end
    if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
    check_wb_zero("reset");
    @(posedge CLK); #1;
    RST = 1'b0; ex_valid = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic test_lb();
    set_ex(1, 1, 0, 3'd0, 32'h1003, 0, 1, 0, 3'd0, 2'd2);
    run_txn(0, -1, 32'h80FF_0000);
    vectors++;
    if (wb_dload_ext !== 32'hFFFF_FF80 || wb_w_sel !== 3'd0) begin miscompares++; $display("FAIL lb got=%h/%h exp=ffffff80/0", wb_dload_ext, wb_w_sel); end
  endtask

  task automatic test_sh_wait();
    set_ex(1, 0, 1, 3'd1, 32'h2002, 32'h0000_ABCD, 0, 0, 3'd3, 2'd0);
    run_txn(3, -1, 32'h0);
  endtask

  task automatic test_misaligned();
    set_ex(1, 1, 0, 3'd2, 32'h3001, 0, 1, 0, 3'd0, 2'd0);
    run_txn(2, -1, 32'h1234_5678);
  endtask

  task automatic test_alu();
    set_ex(1, 0, 0, 3'd2, 32'h1234, 0, 1, 0, 3'd3, 2'd0);
    run_txn(0, -1, 32'h0);
    vectors++;
    if (wb_alu_port_out !== 32'h1234) begin miscompares++; $display("FAIL alu_pass got=%h exp=00001234", wb_alu_port_out); end
  endtask

  task automatic test_flush_wait();
    set_ex(1, 1, 0, 3'd5, 32'h4002, 0, 1, 0, 3'd0, 2'd0);
    run_txn(2, 1, 32'hBEEF_0000);
    // The kill must not leak into the following instruction.
    set_ex(1, 0, 0, 3'd2, 32'h55AA, 0, 1, 0, 3'd3, 2'd0);
    run_txn(0, -1, 32'h0);
  endtask

  task automatic test_fp_load();
    set_ex(1, 1, 0, 3'd2, 32'h6000, 0, 0, 1, 3'd3, 2'd1);
    run_txn(1, -1, 32'h3F80_0000);
    vectors++;
    if (wb_dload_ext !== 32'h3F80_0000) begin miscompares++; $display("FAIL fp_load got=%h exp=3f800000", wb_dload_ext); end
  endtask

  task automatic test_rst_wait();
    set_ex(1, 1, 0, 3'd2, 32'h500, 0, 1, 0, 3'd0, 2'd0);
    dmem_busy = 1'b1; flush = 1'b0;
    @(posedge CLK); #1;
    #2;
    vectors++;
    if (mem_stall !== 1'b1 || dmem_ren !== 1'b1) begin miscompares++; $display("FAIL rst_wait_pre got=%b%b exp=11", mem_stall, dmem_ren); end
    @(posedge CLK); #1;
    RST = 1'b1; ex_valid = 1'b0;
    #2;
    vectors++;
    if (dmem_ren !== 1'b0 || mem_stall !== 1'b0) begin miscompares++; $display("FAIL rst_wait_during got=%b%b exp=00", dmem_ren, mem_stall); end
    @(posedge CLK); #1;
    RST = 1'b0;
    #2;
    vectors++;
    if (dmem_ren !== 1'b0 || mem_stall !== 1'b0) begin miscompares++; $display("FAIL rst_wait_after got=%b%b exp=00", dmem_ren, mem_stall); end
    check_wb_zero("rst_wait");
    dmem_busy = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] types [5];
    int kind, busy_n, fc;
    types = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      busy_n = $urandom_range(0, 3);
      fc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, busy_n) : -1;
      set_ex($urandom_range(0, 7) != 0, kind == 0, kind == 1, types[$urandom_range(0, 4)],
             $urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
      run_txn(busy_n, fc, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_wait();
    test_misaligned();
    test_alu();
    test_flush_wait();
    test_fp_load();
    test_rst_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
